proc_param: RTL and testbench

PROC_PARAM -- requirements
Module: proc_param

---
 rtl/proc_param_if.sv | 30 +++
 rtl/proc_param.sv | 147 ++++++++++++++
 tb/tb_proc_param.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_param_if.sv
// Memory/control port of proc_param: run request, synchronous memory read data,
// registered address/write data/write enable, and the per-instruction done strobe.
interface proc_param_if #(
    parameter int N = 16
);
    logic         run;
    logic [N-1:0] din;
    logic [N-1:0] addr;
    logic [N-1:0] dout;
    logic         w;
    logic         done;

    modport master (
        input  run,
        input  din,
        output addr,
        output dout,
        output w,
        output done
    );

    modport slave (
        output run,
        output din,
        input  addr,
        input  dout,
        input  w,
        input  done
    );
endinterface

// File: rtl/proc_param.sv
// Multi-cycle processor: R0..R6, R7 as PC, A/G staging registers, Z/Nf/C flags, one synchronous memory port.
// Fetch takes T0..T2; mv/mvt/untaken branch finish in T3, everything else in T5 (done marks the last cycle).
module proc_param #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    proc_param_if.master bus
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} state_t;

    state_t       state, state_nxt;
    logic [N-1:0] r [8];
    logic [N-1:0] a_reg, g_reg;
    logic [15:0]  ir;
    logic         z, nf, c;
    logic [N-1:0] addr_q, dout_q;
    logic         w_q;
    logic         done;

    logic [2:0]   iii, x, y;
    logic         m;
    logic [8:0]   d;
    logic [N-1:0] op_val, d_sext, mvt_val;
    logic [N:0]   alu;
    logic         cond_true, short_instr;

    assign iii     = ir[15:13];
    assign m       = ir[12];
    assign x       = ir[11:9];
    assign d       = ir[8:0];
    assign y       = ir[2:0];
    assign op_val  = m ? {{(N-9){1'b0}}, d} : r[y];
    assign d_sext  = {{(N-9){d[8]}}, d};
    assign mvt_val = {ir[7:0], {(N-8){1'b0}}};

    always_comb begin
        cond_true = 1'b0;
        case (x)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = z;
            3'b010:  cond_true = !z;
            3'b011:  cond_true = !c;
            3'b100:  cond_true = c;
            3'b101:  cond_true = !nf;
            3'b110:  cond_true = nf;
            default: cond_true = 1'b0;
        endcase
    end

    assign short_instr = (iii == 3'b000) || ((iii == 3'b001) && (m || !cond_true));

    // Subtract is A + ~Op + 1 so that C is the true carry-out (1 = no borrow).
    always_comb begin
        alu = '0;
        case (iii)
            3'b010:         alu = {1'b0, a_reg} + {1'b0, op_val};
            3'b011, 3'b111: alu = {1'b0, a_reg} + {1'b0, ~op_val} + {{N{1'b0}}, 1'b1};
            3'b110:         alu = {1'b0, a_reg & op_val};
            default:        alu = {1'b0, a_reg + d_sext};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= T0;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T0:      state_nxt = bus.run ? T1 : T0;
            T1:      state_nxt = T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = short_instr ? T0 : T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = T0;
            default: state_nxt = T0;
        endcase
    end

    always_comb begin
        done = 1'b0;
        if ((state == T3 && short_instr) || state == T5) done = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r[i] <= '0;
            a_reg  <= '0;
            g_reg  <= '0;
            ir     <= '0;
            z      <= 1'b0;
            nf     <= 1'b0;
            c      <= 1'b0;
            addr_q <= '0;
            dout_q <= '0;
            w_q    <= 1'b0;
        end else begin
            case (state)
                T0: if (bus.run) begin
                    addr_q <= r[7];
                    r[7]   <= r[7] + {{(N-1){1'b0}}, 1'b1};
                end
                T2: ir <= bus.din[15:0];
                T3: case (iii)
                    3'b000:         r[x] <= op_val;
                    3'b001: begin
                        if (m)              r[x]  <= mvt_val;
                        else if (cond_true) a_reg <= r[7];
                    end
                    3'b100, 3'b101: addr_q <= r[y];
                    default:        a_reg  <= r[x];
                endcase
                T4: case (iii)
                    3'b010, 3'b011, 3'b110, 3'b111: begin
                        g_reg <= alu[N-1:0];
                        z     <= (alu[N-1:0] == '0);
                        nf    <= alu[N-1];
                        c     <= alu[N];
                    end
                    3'b001: g_reg <= alu[N-1:0];
                    3'b101: begin
                        dout_q <= r[x];
                        w_q    <= 1'b1;
                    end
                    default: ;
                endcase
                T5: begin
                    w_q <= 1'b0;
                    case (iii)
                        3'b010, 3'b011, 3'b110: r[x] <= g_reg;
                        3'b001:                 r[7] <= g_reg;
                        3'b100:                 r[x] <= bus.din;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.addr = addr_q;
    assign bus.dout = dout_q;
    assign bus.w    = w_q;
    assign bus.done = done;
endmodule

// File: tb/tb_proc_param.sv
// Bench for proc_param: 16-bit and 24-bit instances on behavioural synchronous memories;
// memory writes are queued as observed and matched against expected writes per program.
module tb_proc_param;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    localparam logic [2:0] OP_MV = 3'd0, OP_MB = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3;
    localparam logic [2:0] OP_LD = 3'd4, OP_ST = 3'd5, OP_AND = 3'd6, OP_CMP = 3'd7;
    localparam logic [15:0] HALT = 16'h21FF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proc_param_if #(.N(16)) bus16 ();
    proc_param_if #(.N(24)) bus24 ();

    proc_param #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    proc_param #(.N(24)) dut24 (.clk(clk), .rst(rst), .bus(bus24));

    logic [15:0] mem16 [256];
    logic [23:0] mem24 [256];
    logic        ld_en, ld_sel;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    always @(posedge clk) begin
        if (ld_en && !ld_sel)  mem16[ld_addr] <= ld_data;
        else if (bus16.w)      mem16[bus16.addr[7:0]] <= bus16.dout;
        bus16.din <= mem16[bus16.addr[7:0]];
    end

    always @(posedge clk) begin
        if (ld_en && ld_sel)   mem24[ld_addr] <= {8'h00, ld_data};
        else if (bus24.w)      mem24[bus24.addr[7:0]] <= bus24.dout;
        bus24.din <= mem24[bus24.addr[7:0]];
    end

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    logic [15:0] prog[$];
    int   w_cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (bus16.w === 1'b1) begin
            obs_q.push_back({32'(bus16.addr), 32'(bus16.dout)});
            w_cyc++;
        end
        if (bus24.w === 1'b1) begin
            obs_q.push_back({32'(bus24.addr), 32'(bus24.dout)});
            w_cyc++;
        end
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic mm,
                                        input logic [2:0] rx, input logic [8:0] dd);
        return {op, mm, rx, dd};
    endfunction
    function automatic logic [15:0] imm(input logic [2:0] op, input logic [2:0] rx, input logic [8:0] k);
        return enc(op, 1'b1, rx, k);
    endfunction
    function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return enc(op, 1'b0, rx, {6'b0, ry});
    endfunction
    function automatic logic [15:0] br(input logic [2:0] cnd, input logic [8:0] off);
        return enc(OP_MB, 1'b0, cnd, off);
    endfunction

    task automatic poke(input logic sel, input logic [7:0] a, input logic [15:0] v);
        ld_sel  = sel;
        ld_addr = a;
        ld_data = v;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en   = 1'b0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        bus16.run = 1'b0;
        bus24.run = 1'b0;
        ld_en     = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        prog.delete();
    endtask

    task automatic load_prog(input logic sel);
        for (int i = 0; i < prog.size(); i++) poke(sel, 8'(i), prog[i]);
    endtask

    task automatic start(input logic sel);
        @(negedge clk);
        rst = 1'b0;
        if (sel) bus24.run = 1'b1;
        else     bus16.run = 1'b1;
    endtask

    task automatic wait_writes(input int budget, output bit timed_out);
        int k = 0;
        while (obs_q.size() < exp_q.size() && k < budget) begin
            @(negedge clk);
            k++;
        end
        timed_out = (obs_q.size() < exp_q.size());
        repeat (30) @(negedge clk);
        bus16.run = 1'b0;
        bus24.run = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus16.run = 1'b0;
        bus24.run = 1'b0;
        ld_en     = 1'b0;
        #1;
        n_cmp++;
        if ({bus16.addr, bus16.dout, bus16.w, bus16.done} !== '0) begin
            n_bad++;
            $display("FAIL reset16: addr=%h dout=%h w=%b done=%b, want all 0",
                     bus16.addr, bus16.dout, bus16.w, bus16.done);
        end
        n_cmp++;
        if ({bus24.addr, bus24.dout, bus24.w, bus24.done} !== '0) begin
            n_bad++;
            $display("FAIL reset24: addr=%h dout=%h w=%b done=%b, want all 0",
                     bus24.addr, bus24.dout, bus24.w, bus24.done);
        end
        n_cmp++;
        if (dut16.r[7] !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_pc: got %h want 0000", dut16.r[7]);
        end
    endtask

    task automatic test_idle_then_run();
        int  first = -1, second = -1;
        logic [15:0] a11 = '0;
        logic z9 = 1'bx;
        bit  to;
        wr_t e, o;
        apply_reset();
        prog.push_back(imm(OP_MV, 3'd0, 9'd5));
        prog.push_back(imm(OP_ADD, 3'd0, 9'd3));
        prog.push_back(imm(OP_MV, 3'd1, 9'h80));
        prog.push_back(rr(OP_ST, 3'd0, 3'd1));
        prog.push_back(HALT);
        load_prog(1'b0);
        exp_q.push_back({32'h80, 32'h8});
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus16.addr !== 16'h0 || bus16.done !== 1'b0 || bus16.w !== 1'b0 || dut16.r[7] !== 16'h0) begin
                n_bad++;
                $display("FAIL idle cycle %0d: addr=%h done=%b w=%b pc=%h, want 0", k, bus16.addr,
                         bus16.done, bus16.w, dut16.r[7]);
            end
        end
        bus16.run = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus16.done === 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 9)  z9  = dut16.z;
            if (k == 11) a11 = bus16.addr;
        end
        n_cmp++;
        if (first != 3) begin
            n_bad++;
            $display("FAIL first_done: cycle %0d, want 3", first);
        end
        n_cmp++;
        if (second != 9) begin
            n_bad++;
            $display("FAIL second_done: cycle %0d, want 9", second);
        end
        n_cmp++;
        if (z9 !== 1'b0) begin
            n_bad++;
            $display("FAIL add_z: got %b want 0", z9);
        end
        n_cmp++;
        if (a11 !== 16'h2) begin
            n_bad++;
            $display("FAIL third_fetch_addr: got %h want 0002", a11);
        end
        wait_writes(500, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL idle_run timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL idle_run write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL idle_run extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_carry_branch();
        bit  to;
        wr_t e, o;
        apply_reset();
        prog.push_back(imm(OP_MV, 3'd2, 9'h80));
        prog.push_back(imm(OP_MB, 3'd1, 9'h0FF));
        prog.push_back(imm(OP_ADD, 3'd1, 9'h0FF));
        prog.push_back(imm(OP_ADD, 3'd1, 9'd1));
        prog.push_back(br(3'b011, 9'd1));
        prog.push_back(rr(OP_ST, 3'd1, 3'd2));
        prog.push_back(br(3'b001, 9'h1FC));
        prog.push_back(rr(OP_ST, 3'd1, 3'd2));
        prog.push_back(HALT);
        load_prog(1'b0);
        exp_q.push_back({32'h80, 32'h0});
        exp_q.push_back({32'h80, 32'h1});
        start(1'b0);
        wait_writes(1000, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL carry_branch timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL carry_branch write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL carry_branch extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_conditions();
        bit  to;
        wr_t e, o;
        logic [7:0] taken1 = 8'b0011_0011;
        logic [7:0] taken2 = 8'b0100_1101;
        apply_reset();
        prog.push_back(imm(OP_MV, 3'd5, 9'h90));
        prog.push_back(rr(OP_SUB, 3'd0, 3'd0));
        for (int cc = 0; cc < 8; cc++) begin
            prog.push_back(imm(OP_MV, 3'd0, 9'(cc)));
            prog.push_back(br(3'(cc), 9'd1));
            prog.push_back(rr(OP_ST, 3'd0, 3'd5));
            if (!taken1[cc]) exp_q.push_back({32'h90, 32'(cc)});
        end
        prog.push_back(imm(OP_MV, 3'd1, 9'd1));
        prog.push_back(imm(OP_CMP, 3'd1, 9'd2));
        for (int cc = 0; cc < 8; cc++) begin
            prog.push_back(imm(OP_MV, 3'd0, 9'(cc)));
            prog.push_back(br(3'(cc), 9'd1));
            prog.push_back(rr(OP_ST, 3'd0, 3'd5));
            if (!taken2[cc]) exp_q.push_back({32'h90, 32'(cc)});
        end
        prog.push_back(HALT);
        load_prog(1'b0);
        start(1'b0);
        wait_writes(3000, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL conditions timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL conditions write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL conditions extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_load_store();
        bit  to;
        wr_t e, o;
        int  w0 = w_cyc;
        apply_reset();
        prog.push_back(imm(OP_MV, 3'd2, 9'h10));
        prog.push_back(imm(OP_MB, 3'd3, 9'h0AB));
        prog.push_back(imm(OP_ADD, 3'd3, 9'h0CD));
        prog.push_back(rr(OP_ST, 3'd3, 3'd2));
        prog.push_back(rr(OP_LD, 3'd4, 3'd2));
        prog.push_back(rr(OP_ADD, 3'd4, 3'd4));
        prog.push_back(imm(OP_MV, 3'd6, 9'h81));
        prog.push_back(rr(OP_ST, 3'd4, 3'd6));
        prog.push_back(HALT);
        load_prog(1'b0);
        exp_q.push_back({32'h10, 32'hABCD});
        exp_q.push_back({32'h81, 32'h579A});
        start(1'b0);
        wait_writes(1000, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL load_store timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        n_cmp++;
        if (w_cyc - w0 != 2) begin
            n_bad++;
            $display("FAIL load_store w_cycles: got %0d want 2", w_cyc - w0);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL load_store write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL load_store extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_jump_and();
        bit  to;
        wr_t e, o;
        apply_reset();
        prog.push_back(imm(OP_MV, 3'd1, 9'h80));
        prog.push_back(imm(OP_MV, 3'd7, 9'd4));
        prog.push_back(imm(OP_MV, 3'd0, 9'd1));
        prog.push_back(HALT);
        prog.push_back(imm(OP_MB, 3'd2, 9'h05A));
        prog.push_back(imm(OP_ADD, 3'd2, 9'h0FF));
        prog.push_back(imm(OP_AND, 3'd2, 9'h0F0));
        prog.push_back(rr(OP_ST, 3'd2, 3'd1));
        prog.push_back(rr(OP_ST, 3'd0, 3'd1));
        prog.push_back(rr(OP_ST, 3'd7, 3'd1));
        prog.push_back(HALT);
        load_prog(1'b0);
        exp_q.push_back({32'h80, 32'h00F0});
        exp_q.push_back({32'h80, 32'h0000});
        exp_q.push_back({32'h80, 32'h000A});
        start(1'b0);
        wait_writes(1000, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL jump_and timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL jump_and write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL jump_and extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_store();
        bit  to;
        int  k = 0;
        int  w0;
        wr_t e, o;
        apply_reset();
        poke(1'b0, 8'h40, 16'h1234);
        prog.push_back(imm(OP_MV, 3'd2, 9'h40));
        prog.push_back(imm(OP_MV, 3'd3, 9'd7));
        prog.push_back(rr(OP_ST, 3'd3, 3'd2));
        prog.push_back(HALT);
        load_prog(1'b0);
        w0 = w_cyc;
        start(1'b0);
        while (bus16.addr !== 16'h40 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus16.addr !== 16'h40) begin
            n_bad++;
            $display("FAIL mid_store reach T4: addr=%h want 0040", bus16.addr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus16.w !== 1'b0 || bus16.addr !== 16'h0 || bus16.dout !== 16'h0) begin
            n_bad++;
            $display("FAIL mid_store async clear: w=%b addr=%h dout=%h want 0", bus16.w, bus16.addr, bus16.dout);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem16[8'h40] !== 16'h1234 || w_cyc != w0) begin
            n_bad++;
            $display("FAIL mid_store no write: mem=%h w_cycles=%0d want 1234 and 0", mem16[8'h40], w_cyc - w0);
        end
        exp_q.push_back({32'h40, 32'h7});
        rst = 1'b0;
        wait_writes(500, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL mid_store restart timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL mid_store restart write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_store extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    task automatic test_n24();
        bit  to;
        wr_t e, o;
        apply_reset();
        prog.push_back(imm(OP_MV, 3'd1, 9'h80));
        prog.push_back(imm(OP_MB, 3'd5, 9'h012));
        prog.push_back(rr(OP_CMP, 3'd5, 3'd5));
        prog.push_back(br(3'b010, 9'd1));
        prog.push_back(rr(OP_ST, 3'd5, 3'd1));
        prog.push_back(br(3'b011, 9'd1));
        prog.push_back(rr(OP_ST, 3'd5, 3'd1));
        prog.push_back(HALT);
        load_prog(1'b1);
        exp_q.push_back({32'h80, 32'h120000});
        exp_q.push_back({32'h80, 32'h120000});
        start(1'b1);
        wait_writes(1000, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL n24 timeout: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL n24 write: got a=%h d=%h want a=%h d=%h", o.a, o.d, e.a, e.d);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL n24 extra writes: got %0d want 0", obs_q.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_then_run();
        test_carry_branch();
        test_conditions();
        test_load_store();
        test_jump_and();
        test_reset_mid_store();
        test_n24();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
